// File: rtl/hex_reg_loader_pkg.sv
// ---------------------------------------------------------------------------
// hex_reg_loader_pkg
// Shared types and constants for the hex D-register load sequencer.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package hex_reg_loader_pkg;

  // Width of the downstream hex D-register
  localparam int HEX_W = 6;

  // Default timing, in system clock cycles
  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_PULSE_CYCLES = 1;
  localparam int DEF_HOLD_CYCLES  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_CLEAR  = 3'd4
  } state_e;

  // Largest of three interval lengths; sizes the shared down-counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_reg_loader_timer.sv
// ---------------------------------------------------------------------------
// hex_reg_loader_timer
// Loadable down-counter that stops at zero; tc_o flags the last cycle of
// the interval being timed.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hex_reg_loader_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load on request, otherwise count down and park at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/hex_reg_loader.sv
// ---------------------------------------------------------------------------
// hex_reg_loader
// Drives D/CLK/_MR of a 74174-class hex register: accepts a word on a
// valid/ready handshake, holds it for a setup interval, pulses the register
// clock, holds it afterwards, and issues clears on request.
// Optional feature macro: HEX_REG_LOADER_READBACK_EN (readback check -> ERR).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hex_reg_loader
  import hex_reg_loader_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic             clk_i,
  input  logic             mr_n_i,
  input  logic [HEX_W-1:0] d_in_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             clr_req_i,
  input  logic [HEX_W-1:0] q_in_i,
  output logic [HEX_W-1:0] reg_d_o,
  output logic             reg_clk_o,
  output logic             reg_mr_n_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);

  state_e           state_q, state_d;
  logic [HEX_W-1:0] reg_d_q, reg_d_d;
  logic             reg_clk_q, reg_clk_d;
  logic             reg_mr_n_q, reg_mr_n_d;
  logic             load_ready_q, load_ready_d;
  logic             tmr_load, tmr_tc;
  logic [CNT_W-1:0] tmr_val;
  logic             accept_clr, accept_load;

  // A request only counts once READY is actually visible to the requester;
  // clear takes priority over a simultaneous load
  assign accept_clr  = (state_q == ST_IDLE) && load_ready_q && clr_req_i;
  assign accept_load = (state_q == ST_IDLE) && load_ready_q && !clr_req_i && load_valid_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!mr_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; each timed state leaves on the counter's terminal count
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_clr) begin
          state_d = ST_CLEAR;
        end else if (accept_load) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:  if (tmr_tc) state_d = ST_STROBE;
      ST_STROBE: if (tmr_tc) state_d = ST_HOLD;
      ST_HOLD:   if (tmr_tc) state_d = ST_IDLE;
      ST_CLEAR:  if (tmr_tc) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered pins
  // change on the same edge as the state itself
  always_comb begin
    reg_d_d      = accept_load ? d_in_i : reg_d_q;
    reg_clk_d    = (state_d == ST_STROBE);
    reg_mr_n_d   = (state_d != ST_CLEAR);
    load_ready_d = (state_d == ST_IDLE);
  end

  // Output registers; reset forces REG_CLK low and asserts the register clear
  always_ff @(posedge clk_i) begin
    if (!mr_n_i) begin
      reg_d_q      <= '0;
      reg_clk_q    <= 1'b0;
      reg_mr_n_q   <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      reg_d_q      <= reg_d_d;
      reg_clk_q    <= reg_clk_d;
      reg_mr_n_q   <= reg_mr_n_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Counter is reloaded with (length - 1) whenever a timed state is entered
  always_comb begin
    tmr_load = (state_d != state_q) && (state_d != ST_IDLE);
    case (state_d)
      ST_SETUP:  tmr_val = CNT_W'(SETUP_CYCLES - 1);
      ST_STROBE: tmr_val = CNT_W'(PULSE_CYCLES - 1);
      ST_HOLD:   tmr_val = CNT_W'(HOLD_CYCLES - 1);
      ST_CLEAR:  tmr_val = CNT_W'(PULSE_CYCLES - 1);
      default:   tmr_val = '0;
    endcase
  end

  hex_reg_loader_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (mr_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  assign reg_d_o      = reg_d_q;
  assign reg_clk_o    = reg_clk_q;
  assign reg_mr_n_o   = reg_mr_n_q;
  assign load_ready_o = load_ready_q;

`ifdef HEX_REG_LOADER_READBACK_EN
  logic err_q, err_d;
  logic clr_done_q;
  logic mismatch;

  // Compare Q at the end of HOLD and in the first IDLE cycle after a clear
  always_comb begin
    mismatch = 1'b0;
    if ((state_q == ST_HOLD) && tmr_tc && (q_in_i != reg_d_q)) begin
      mismatch = 1'b1;
    end
    if (clr_done_q && (q_in_i != '0)) begin
      mismatch = 1'b1;
    end
    err_d = err_q | mismatch;
  end

  // Sticky error flag and marker for the cycle following a finished clear
  always_ff @(posedge clk_i) begin
    if (!mr_n_i) begin
      err_q      <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      clr_done_q <= (state_q == ST_CLEAR) && (state_d == ST_IDLE);
    end
  end

  assign err_o = err_q;
`else
  // Readback not built: Q is intentionally ignored
  logic unused_q_in;
  assign unused_q_in = ^q_in_i;
  assign err_o       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hex_reg_loader.sv
// ---------------------------------------------------------------------------
// tb_hex_reg_loader
// Directed bench for hex_reg_loader with a behavioural 74174 downstream
// register and a queue of expected register contents.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hex_reg_loader;

  logic       clk;
  logic       mr_n;
  logic [5:0] d_in;
  logic       load_valid;
  logic       load_ready;
  logic       clr_req;
  logic [5:0] q_in;
  logic [5:0] reg_d;
  logic       reg_clk;
  logic       reg_mr_n;
  logic       err;

  logic [5:0] q_model;
  logic       force_q;
  int         tests;
  int         fails;
  int         pulses;
  int         glitches;
  int         p_snap;
  logic [5:0] sb_q[$];

`ifdef HEX_REG_LOADER_READBACK_EN
  localparam logic RB_ERR = 1'b1;
`else
  localparam logic RB_ERR = 1'b0;
`endif

  hex_reg_loader dut (
    .clk_i        (clk),
    .mr_n_i       (mr_n),
    .d_in_i       (d_in),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .clr_req_i    (clr_req),
    .q_in_i       (q_in),
    .reg_d_o      (reg_d),
    .reg_clk_o    (reg_clk),
    .reg_mr_n_o   (reg_mr_n),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 74174: rising-edge clock, asynchronous active-low clear
  initial q_model = 6'b0;
  always @(posedge reg_clk or negedge reg_mr_n) begin
    if (!reg_mr_n) q_model <= 6'b0;
    else           q_model <= reg_d;
  end

  assign q_in = force_q ? 6'b000001 : q_model;

  initial pulses = 0;
  always @(posedge reg_clk) pulses = pulses + 1;

  initial glitches = 0;
  always @(reg_d) if (reg_clk === 1'b1) glitches = glitches + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [5:0] e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, {2'b00, q_model}, {2'b00, e});
    end
  endtask

  initial begin
    tests = 0; fails = 0; force_q = 1'b0;
    mr_n = 1'b0; d_in = 6'b0; load_valid = 1'b0; clr_req = 1'b0;

    // Reset for two edges
    tick(); tick();
    check("rst_reg_d",  {2'b0, reg_d}, 8'h00);
    check("rst_clk",    {7'b0, reg_clk}, 8'h00);
    check("rst_mr_n",   {7'b0, reg_mr_n}, 8'h00);
    check("rst_ready",  {7'b0, load_ready}, 8'h00);
    check("rst_err",    {7'b0, err}, 8'h00);
    mr_n = 1'b1;
    tick();
    check("rel_mr_n",   {7'b0, reg_mr_n}, 8'h01);
    check("rel_ready",  {7'b0, load_ready}, 8'h01);

    // Single load 101010
    d_in = 6'b101010; load_valid = 1'b1; sb_q.push_back(6'b101010);
    tick();                                  // t0
    load_valid = 1'b0; d_in = 6'b000000;
    check("ld_d_t0",    {2'b0, reg_d}, 8'b00101010);
    check("ld_rdy_t0",  {7'b0, load_ready}, 8'h00);
    check("ld_clk_t0",  {7'b0, reg_clk}, 8'h00);
    tick();                                  // t0+1
    check("ld_clk_t1",  {7'b0, reg_clk}, 8'h00);
    tick();                                  // t0+2
    check("ld_clk_t2",  {7'b0, reg_clk}, 8'h01);
    check("ld_d_t2",    {2'b0, reg_d}, 8'b00101010);
    tick();                                  // t0+3
    check("ld_clk_t3",  {7'b0, reg_clk}, 8'h00);
    check("ld_rdy_t3",  {7'b0, load_ready}, 8'h00);
    check("ld_d_t3",    {2'b0, reg_d}, 8'b00101010);
    tick();                                  // t0+4
    check("ld_rdy_t4",  {7'b0, load_ready}, 8'h01);
    check_sb("ld_q");

    // Back-to-back loads with LOAD_VALID held high
    d_in = 6'b101010; load_valid = 1'b1; sb_q.push_back(6'b101010);
    tick();                                  // t0
    d_in = 6'b010101; sb_q.push_back(6'b010101);
    repeat (3) tick();                       // t0+3
    check("b2b_rdy_t3", {7'b0, load_ready}, 8'h00);
    tick();                                  // t0+4
    check("b2b_rdy_t4", {7'b0, load_ready}, 8'h01);
    check("b2b_d_t4",   {2'b0, reg_d}, 8'b00101010);
    check_sb("b2b_q1");
    tick();                                  // t0+5: second accept
    load_valid = 1'b0;
    check("b2b_acc2",   {7'b0, load_ready}, 8'h00);
    check("b2b_d_t5",   {2'b0, reg_d}, 8'b00010101);
    repeat (4) tick();
    check("b2b_rdy_end", {7'b0, load_ready}, 8'h01);
    check_sb("b2b_q2");
    check("b2b_glitch", glitches[7:0], 8'h00);
    check("b2b_pulses", pulses[7:0], 8'h03);

    // Clear wins over a simultaneous load
    d_in = 6'b111111; load_valid = 1'b1; clr_req = 1'b1; sb_q.push_back(6'b000000);
    tick();
    load_valid = 1'b0; clr_req = 1'b0;
    check("clr_mr_n",   {7'b0, reg_mr_n}, 8'h00);
    check("clr_rdy",    {7'b0, load_ready}, 8'h00);
    check("clr_d",      {2'b0, reg_d}, 8'b00010101);
    tick();
    check("clr_mr_n_end", {7'b0, reg_mr_n}, 8'h01);
    check("clr_rdy_end",  {7'b0, load_ready}, 8'h01);
    check("clr_d_end",    {2'b0, reg_d}, 8'b00010101);
    check_sb("clr_q");
    tick();
    check("clr_err",    {7'b0, err}, 8'h00);

    // Reset in the middle of STROBE
    d_in = 6'b000111; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(); tick();
    check("ab_strobe",  {7'b0, reg_clk}, 8'h01);
    p_snap = pulses;
    mr_n = 1'b0;
    tick();
    check("ab_clk",     {7'b0, reg_clk}, 8'h00);
    check("ab_mr_n",    {7'b0, reg_mr_n}, 8'h00);
    check("ab_rdy",     {7'b0, load_ready}, 8'h00);
    check("ab_q",       {2'b0, q_model}, 8'h00);
    mr_n = 1'b1;
    tick();
    check("ab_rel_rdy", {7'b0, load_ready}, 8'h01);
    repeat (6) tick();
    check("ab_no_pulse", pulses[7:0], p_snap[7:0]);
    check("ab_d",       {2'b0, reg_d}, 8'h00);

    // Readback mismatch then a good load
    force_q = 1'b1;
    d_in = 6'b101010; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (3) tick();                       // last HOLD cycle
    check("rb_err_pre", {7'b0, err}, 8'h00);
    tick();
    check("rb_err_set", {7'b0, err}, {7'b0, RB_ERR});
    force_q = 1'b0;
    d_in = 6'b010101; load_valid = 1'b1; sb_q.push_back(6'b010101);
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    check_sb("rb_good_q");
    check("rb_err_sticky", {7'b0, err}, {7'b0, RB_ERR});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_reg_loader.md
# hex_reg_loader

Sequencer that sits directly upstream of the 6-bit hex D-register (74174-class, rising-edge CLK, async-clear `_MR`) and drives its `D`, `CLK` and `_MR` pins. It accepts 6-bit words on a valid/ready handshake and presents each word for a programmable setup interval. It then pulses the register clock and holds `D` stable afterwards, so the downstream register never samples inside its setup window. It also issues register clears on request and, optionally, verifies the register contents by readback.

## Interface
- `SETUP_CYCLES`, default 2: cycles `REG_D` is stable before `REG_CLK` rises; must be ≥1.
- `PULSE_CYCLES`, default 1: cycles `REG_CLK` is high. Also the number of cycles `_REG_MR` is low for a clear. Must be ≥1.
- `HOLD_CYCLES`, default 1: cycles `REG_D` is held after `REG_CLK` falls; must be ≥1.
- `CLK` in 1: system clock; all state changes on the rising edge.
- `_MR` in 1: reset, synchronous, active-low.
- `D_IN` in 6: word to load.
- `LOAD_VALID` in 1: `D_IN` is valid.
- `LOAD_READY` out 1: sequencer can accept a load.
- `CLR_REQ` in 1: request a clear of the downstream register.
- `Q_IN` in 6: downstream register `Q`, used for readback.
- `REG_D` out 6: drives the register's `D` pins.
- `REG_CLK` out 1: drives the register's `CLK` pin.
- `_REG_MR` out 1: drives the register's `_MR` pin (active-low).
- `ERR` out 1: sticky readback-mismatch flag.

## Operation
- All outputs are registered, so there are no combinational paths from input to output.
- Reset values (`_MR` low at an edge): state IDLE, `REG_D`=000000, `REG_CLK`=0, `_REG_MR`=0, `LOAD_READY`=0, `ERR`=0.
  - `_REG_MR` goes to 1 and `LOAD_READY` goes to 1 on the first edge with `_MR` high.
- States: IDLE, SETUP, STROBE, HOLD, CLEAR.
- IDLE: `LOAD_READY`=1, `REG_CLK`=0, `_REG_MR`=1.
  - `CLR_REQ`=1 → CLEAR. `CLR_REQ` wins over a simultaneous `LOAD_VALID`; that load is not accepted.
  - Else `LOAD_VALID`=1 → load accepted: `REG_D`←`D_IN`, go to SETUP.
- SETUP (`SETUP_CYCLES` cycles): `REG_D` held, `REG_CLK`=0 → STROBE.
- STROBE (`PULSE_CYCLES` cycles): `REG_CLK`=1 → HOLD.
- HOLD (`HOLD_CYCLES` cycles): `REG_CLK`=0, `REG_D` held → IDLE.
- CLEAR (`PULSE_CYCLES` cycles): `_REG_MR`=0, `REG_CLK`=0 → IDLE. `REG_D` is unchanged.
- Outside IDLE: `LOAD_READY`=0 and `LOAD_VALID`/`CLR_REQ` are ignored. Requests are not queued; the requester must hold them until accepted.
- A single down-counter times each state, loaded on state entry with (count−1). Counter width is `$clog2(max(S,P,H)+1)`.
- Reset in any state aborts the in-flight operation at that edge and forces the reset values (`REG_CLK` drops, `_REG_MR` asserts). Nothing is retried.

## Timing
- Accept edge is t0 (`LOAD_VALID`&`LOAD_READY` sampled high).
  - `REG_D` is valid after t0.
  - `REG_CLK` rises after edge t0+S and falls after edge t0+S+P.
  - `LOAD_READY` rises after edge t0+S+P+H.
- The earliest next accept is edge t0+S+P+H+1, so sustained throughput is one word per S+P+H+1 cycles. With defaults: 5 cycles.
- `REG_D` is stable from S cycles before the `REG_CLK` rise until H cycles after its fall.
- A clear accepted at t0 drives `_REG_MR` low after edge t0 and returns it high after edge t0+P. `LOAD_READY` returns after edge t0+P.

## Configuration
- `HEX_REG_LOADER_READBACK_EN` defined:
  - On the last HOLD cycle, `Q_IN` is compared with `REG_D`.
  - On the first IDLE cycle after CLEAR, `Q_IN` is compared with 000000.
  - Any mismatch sets `ERR` at the next edge. `ERR` stays set until `_MR`.
- Not defined: the `Q_IN` port remains and is ignored, `ERR` is constant 0, and no compare logic is built.

## Structure
- Package `hex_reg_loader_pkg` holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, CLEAR);
  - `HEX_W`=6;
  - default timing constants.
- Sub-module `hex_reg_loader_timer` is the loadable down-counter with a terminal-count output, parameterised on width.

## Test plan
- Reset: `_MR`=0 for 2 edges → `REG_D`=000000, `REG_CLK`=0, `_REG_MR`=0, `LOAD_READY`=0. First edge with `_MR`=1 → `_REG_MR`=1, `LOAD_READY`=1.
- Single load at defaults, `D_IN`=101010 → `REG_CLK` high exactly during cycle 3, `REG_D`=101010 from cycle 1 to 4, `LOAD_READY` back after edge 4. A bench hct74174 ends with `Q`=101010.
- Back-to-back loads 101010 then 010101, with `LOAD_VALID` held high → second accept at edge 5, final `Q`=010101, and `REG_D` never changes while `REG_CLK`=1.
- Simultaneous `CLR_REQ`=1 and `LOAD_VALID`=1 in IDLE → CLEAR taken and `_REG_MR` low 1 cycle, `Q`=000000, load not accepted (`REG_D` unchanged).
- Reset mid-STROBE → `REG_CLK`=0 and `_REG_MR`=0 at the reset edge, state IDLE, no second `REG_CLK` pulse after release.
- With `HEX_REG_LOADER_READBACK_EN`, `Q_IN` forced to 000001 during a load of 101010 → `ERR`=1 after the HOLD edge and still 1 after a subsequent good load. Without the macro, `ERR`=0 throughout.
